junction_lamp_ctrl: RTL and testbench
=====================================

// Module: junction_lamp_ctrl
// PURPOSE
//  Sequences two cyclic RGY lamp heads (main road, side road) plus a pedestrian
//  WALK lamp at one junction. Main road rests on green. Latched side-road sensor
//  and pedestrian push-button requests are served through timed yellow,
//  all-red and walk phases. Sits between the sensors/buttons and the lamp
//  drivers.
// PARAMETERS
//  CW           4  width of the phase timer
//  T_MAIN_GREEN 8  minimum main-green cycles before a request is served
//  T_SIDE_GREEN 4  side-green cycles (fixed)
//  T_YELLOW     2  yellow cycles (both roads)
//  T_ALLRED     1  all-red clearance cycles
//  T_WALK       4  pedestrian walk cycles
//  Legal range of every T_*: 1 .. 2**CW.
// PORTS
//  clock       in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  side_req    in   1      side-road vehicle sensor (level or 1-cycle pulse)
//  ped_req     in   1      pedestrian button (level or 1-cycle pulse)
//  main_light  out  [0:2]  main-road RGY: red=100, green=010, yellow=001
//  side_light  out  [0:2]  side-road RGY, same encoding
//  walk        out  1      pedestrian WALK lamp
//  ped_ack     out  1      1-cycle pulse: pedestrian request accepted
//  phase       out  [2:0]  current state code (debug/status)
// BEHAVIOUR
//  States and phase codes; main/side/walk are a Moore decode of the state reg:
//   0 MAIN_GREEN  010/100/0    1 MAIN_YELLOW 001/100/0   2 ALL_RED_A 100/100/0
//   3 PED_WALK    100/100/1    4 SIDE_GREEN  100/010/0   5 SIDE_YELLOW 100/001/0
//   6 ALL_RED_B   100/100/0.  Codes 7 and any illegal state -> ALL_RED_B next edge.
//  Reset (async, takes effect immediately): state=ALL_RED_B, timer=T_ALLRED-1,
//   side_pend=0, ped_pend=0, ped_ack=0. Outputs are 100/100/0, phase=6.
//  Timer: load T_x-1 on entry to state x. Decrement each cycle. Saturate at 0.
//   A timed state lasts exactly T_x cycles.
//  Transitions, taken on the edge where timer==0:
//   MAIN_GREEN -> MAIN_YELLOW only if side_pend|ped_pend. Otherwise hold green
//     indefinitely. A request arriving after the minimum exits on the next edge.
//   MAIN_YELLOW -> ALL_RED_A
//   ALL_RED_A  -> PED_WALK if ped_pend, else SIDE_GREEN
//   PED_WALK   -> SIDE_GREEN if side_pend, else ALL_RED_B
//   SIDE_GREEN -> SIDE_YELLOW -> ALL_RED_B -> MAIN_GREEN
//  Request latches:
//   side_pend is set by side_req=1. It is cleared on entry to SIDE_GREEN.
//     side_req while in SIDE_GREEN is ignored.
//   ped_pend is set by ped_req=1 when ped_pend=0 and state!=PED_WALK.
//     It is cleared on entry to PED_WALK.
//   ped_ack is registered and high exactly in the cycle after ped_pend goes
//     0->1. A held ped_req produces one ack per service.
//   Set and clear in the same cycle: the clear wins. The request counts as served.
//  Safety invariant: main_light and side_light are never both non-red.
//   walk=1 only while both lamps are red.
//  Latency: a request seen in MAIN_GREEN with the minimum elapsed reaches a
//   non-red side lamp or walk after T_YELLOW+T_ALLRED+1 edges.
// TESTING (defaults; cycle n = n-th rising edge after reset deassert)
//  Reset, no requests -> phase 6 for 1 cycle, then phase 0 held >=50 cycles.
//   side_light=100, walk=0, ped_ack=0 throughout.
//  side_req pulse at cycle 3 -> main green to cycle 8, yellow 9-10, all-red 11,
//   side green 12-15, side yellow 16-17, all-red 18, main green from 19.
//  ped_req pulse at cycle 20 -> ped_ack=1 for one cycle, then path 0,1,2,3
//   (walk=1 for 4 cycles) ->6->0. No side green occurs.
//  side_req and ped_req together after the main-green minimum -> 1,2,3,4,5,6,0.
//   One ped_ack. walk and side green never overlap.
//  ped_req held high across a full service -> exactly one ped_ack per service.
//   Re-latched after PED_WALK, so a second cycle follows.
//  reset asserted during SIDE_GREEN -> outputs 100/100/0 and phase 6 the same
//   cycle, with no clock. Pending flags cleared.
//  All runs: assert the safety invariant every cycle.

Source files
------------

// File: rtl/junction_lamp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : junction_lamp_ctrl
//  Description : Two-road junction lamp sequencer with pedestrian WALK phase.
//                Main road rests on green; latched side-road and pedestrian
//                requests are served through timed yellow, all-red and walk
//                phases.
//  Ports       : clock_i      - system clock, rising edge
//                reset_i      - asynchronous active-high reset
//                side_req_i   - side-road vehicle sensor (level or pulse)
//                ped_req_i    - pedestrian button (level or pulse)
//                main_light_o - main-road RGY lamps (red=100 green=010 yellow=001)
//                side_light_o - side-road RGY lamps, same encoding
//                walk_o       - pedestrian WALK lamp
//                ped_ack_o    - one-cycle pulse when a pedestrian request latches
//                phase_o      - current state code
//  Revision    : 1.0 - initial release
// ============================================================================
module junction_lamp_ctrl #(
  parameter int CW           = 4,
  parameter int T_MAIN_GREEN = 8,
  parameter int T_SIDE_GREEN = 4,
  parameter int T_YELLOW     = 2,
  parameter int T_ALLRED     = 1,
  parameter int T_WALK       = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       side_req_i,
  input  logic       ped_req_i,
  output logic [0:2] main_light_o,
  output logic [0:2] side_light_o,
  output logic       walk_o,
  output logic       ped_ack_o,
  output logic [2:0] phase_o
);

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_ALL_RED_A   = 3'd2;
  localparam logic [2:0] S_PED_WALK    = 3'd3;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd4;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd5;
  localparam logic [2:0] S_ALL_RED_B   = 3'd6;

  // Timer reload values: a state lasts T_x cycles, so the timer starts at T_x-1.
  localparam logic [CW-1:0] LD_MAIN_GREEN = CW'(T_MAIN_GREEN - 1);
  localparam logic [CW-1:0] LD_SIDE_GREEN = CW'(T_SIDE_GREEN - 1);
  localparam logic [CW-1:0] LD_YELLOW     = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] LD_ALLRED     = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LD_WALK       = CW'(T_WALK - 1);

  localparam logic [0:2] L_RED    = 3'b100;
  localparam logic [0:2] L_GREEN  = 3'b010;
  localparam logic [0:2] L_YELLOW = 3'b001;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          side_pend_q, side_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ped_ack_q, ped_ack_d;
  logic          entering;
  logic          timer_done;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_ALL_RED_B;
      timer_q     <= LD_ALLRED;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
    end
  end

  // Next-state, timer and request-latch logic
  always_comb begin
    timer_done = (timer_q == '0);
    state_d    = state_q;
    case (state_q)
      S_MAIN_GREEN:  if (timer_done && (side_pend_q || ped_pend_q)) state_d = S_MAIN_YELLOW;
      S_MAIN_YELLOW: if (timer_done) state_d = S_ALL_RED_A;
      S_ALL_RED_A:   if (timer_done) state_d = ped_pend_q ? S_PED_WALK : S_SIDE_GREEN;
      S_PED_WALK:    if (timer_done) state_d = side_pend_q ? S_SIDE_GREEN : S_ALL_RED_B;
      S_SIDE_GREEN:  if (timer_done) state_d = S_SIDE_YELLOW;
      S_SIDE_YELLOW: if (timer_done) state_d = S_ALL_RED_B;
      S_ALL_RED_B:   if (timer_done) state_d = S_MAIN_GREEN;
      default:       state_d = S_ALL_RED_B;
    endcase

    // No state loops to itself, so any change of code is a state entry.
    entering = (state_d != state_q);

    if (entering) begin
      case (state_d)
        S_MAIN_GREEN:  timer_d = LD_MAIN_GREEN;
        S_MAIN_YELLOW: timer_d = LD_YELLOW;
        S_PED_WALK:    timer_d = LD_WALK;
        S_SIDE_GREEN:  timer_d = LD_SIDE_GREEN;
        S_SIDE_YELLOW: timer_d = LD_YELLOW;
        default:       timer_d = LD_ALLRED;
      endcase
    end else if (timer_done) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q - 1'b1;
    end

    // Clear on service entry takes priority over a coincident set.
    side_pend_d = side_pend_q;
    if (entering && state_d == S_SIDE_GREEN) begin
      side_pend_d = 1'b0;
    end else if (side_req_i && state_q != S_SIDE_GREEN) begin
      side_pend_d = 1'b1;
    end

    ped_pend_d = ped_pend_q;
    if (entering && state_d == S_PED_WALK) begin
      ped_pend_d = 1'b0;
    end else if (ped_req_i && !ped_pend_q && state_q != S_PED_WALK) begin
      ped_pend_d = 1'b1;
    end

    ped_ack_d = ped_pend_d & ~ped_pend_q;
  end

  // Moore output decode
  always_comb begin
    main_light_o = L_RED;
    side_light_o = L_RED;
    walk_o       = 1'b0;
    case (state_q)
      S_MAIN_GREEN:  main_light_o = L_GREEN;
      S_MAIN_YELLOW: main_light_o = L_YELLOW;
      S_PED_WALK:    walk_o       = 1'b1;
      S_SIDE_GREEN:  side_light_o = L_GREEN;
      S_SIDE_YELLOW: side_light_o = L_YELLOW;
      default:       main_light_o = L_RED;
    endcase
  end

  assign ped_ack_o = ped_ack_q;
  assign phase_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_junction_lamp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_junction_lamp_ctrl
//  Description : Self-checking bench for junction_lamp_ctrl. A phase-level
//                reference model predicts every cycle's outputs into a queue;
//                a negedge monitor pops and compares, and also checks the
//                lamp safety invariant. Directed sequences cover the timing
//                examples, request combinations and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_junction_lamp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  junction_lamp_ctrl #(
    .CW(4), .T_MAIN_GREEN(8), .T_SIDE_GREEN(4), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(4)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .side_req_i  (side_req),
    .ped_req_i   (ped_req),
    .main_light_o(main_light),
    .side_light_o(side_light),
    .walk_o      (walk),
    .ped_ack_o   (ped_ack),
    .phase_o     (phase)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase + elapsed cycles) --------------
  int dur[7] = '{8, 2, 1, 4, 4, 2, 1};   // cycles per phase (phase 0 = minimum)
  int m_ph = 6;
  int m_el = 1;
  bit m_sp = 0;
  bit m_pp = 0;
  bit m_ack = 0;
  logic [10:0] exp_q[$];

  // {main, side, walk} for each phase
  function automatic logic [6:0] lamps(input int p);
    case (p)
      0:       return {3'b010, 3'b100, 1'b0};
      1:       return {3'b001, 3'b100, 1'b0};
      3:       return {3'b100, 3'b100, 1'b1};
      4:       return {3'b100, 3'b010, 1'b0};
      5:       return {3'b100, 3'b001, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 6; m_el = 1; m_sp = 0; m_pp = 0; m_ack = 0;
    exp_q.delete();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      int np;
      bit ns, npp;
      np = m_ph;
      if (m_el >= dur[m_ph]) begin
        case (m_ph)
          0: if (m_sp || m_pp) np = 1;
          1: np = 2;
          2: np = m_pp ? 3 : 4;
          3: np = m_sp ? 4 : 6;
          4: np = 5;
          5: np = 6;
          default: np = 0;
        endcase
      end
      ns = m_sp;
      if (np == 4 && m_ph != 4) ns = 0;
      else if (side_req && m_ph != 4) ns = 1;
      npp = m_pp;
      if (np == 3 && m_ph != 3) npp = 0;
      else if (ped_req && !m_pp && m_ph != 3) npp = 1;
      m_ack = !m_pp && npp;
      m_el  = (np != m_ph) ? 1 : m_el + 1;
      m_ph  = np;
      m_sp  = ns;
      m_pp  = npp;
      exp_q.push_back({3'(np), lamps(np), m_ack});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [10:0] act;
    act = {phase, main_light, side_light, walk, ped_ack};
    n_chk++;
    if ((main_light != 3'b100 && side_light != 3'b100) ||
        (walk && (main_light != 3'b100 || side_light != 3'b100))) begin
      n_fail++;
      $display("FAIL safety: main=%b side=%b walk=%b at %0t", main_light, side_light, walk, $time);
    end
    if (rst) begin
      chk("reset_outputs", 32'(act), 32'({3'd6, 3'b100, 3'b100, 1'b0, 1'b0}));
    end else if (exp_q.size() > 0) begin
      chk("scoreboard", 32'(act), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  function automatic int spec_phase(input int n);
    if (n <= 8)  return 0;
    if (n <= 10) return 1;
    if (n == 11) return 2;
    if (n <= 15) return 4;
    if (n <= 17) return 5;
    if (n == 18) return 6;
    if (n <= 26) return 0;
    if (n <= 28) return 1;
    if (n == 29) return 2;
    if (n <= 33) return 3;
    if (n == 34) return 6;
    return 0;
  endfunction

  task automatic release_reset();
    side_req = 0; ped_req = 0;
    @(negedge clk); #2 rst = 0;
  endtask

  initial begin
    int seen[$];
    int exp_seq[7] = '{1, 2, 3, 4, 5, 6, 0};
    bit found;
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    release_reset();

    // Side pulse at cycle 3, pedestrian pulse at cycle 20.
    for (int n = 1; n <= 40; n++) begin
      side_req = (n == 3);
      ped_req  = (n == 20);
      @(posedge clk); #1;
      chk($sformatf("dir_phase_c%0d", n), 32'(phase), 32'(spec_phase(n)));
      chk($sformatf("dir_ack_c%0d", n), 32'(ped_ack), 32'(n == 20));
    end
    side_req = 0; ped_req = 0;

    // Reach SIDE_GREEN, latch a ped request, then reset asynchronously.
    side_req = 1;
    @(posedge clk); #1 side_req = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (phase == 3'd4) found = 1;
    end
    chk("reach_side_green", 32'(found), 32'd1);
    ped_req = 1;
    @(posedge clk); #1 ped_req = 0;
    #2 rst = 1;
    #1;
    chk("async_reset_phase", 32'(phase), 32'd6);
    chk("async_reset_lamps", 32'({main_light, side_light, walk, ped_ack}), 32'({3'b100, 3'b100, 2'b00}));
    @(posedge clk);
    release_reset();

    // Idle: pending flags were cleared, so green is held.
    for (int n = 1; n <= 55; n++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_c%0d", n), 32'({phase, side_light, walk, ped_ack}), 32'({3'd0, 3'b100, 2'b00}));
    end

    // Both requests together after the minimum: 1,2,3,4,5,6,0.
    side_req = 1; ped_req = 1;
    @(posedge clk); #1 side_req = 0; ped_req = 0;
    seen.push_back(int'(phase));
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (int'(phase) != seen[$]) seen.push_back(int'(phase));
    end
    chk("both_seq_len", 32'(seen.size()), 32'd8);
    for (int k = 0; k < 7; k++)
      if (k + 1 < seen.size()) chk($sformatf("both_seq_%0d", k), 32'(seen[k+1]), 32'(exp_seq[k]));

    // Randomized traffic with a held-button stretch.
    for (int i = 0; i < 3000; i++) begin
      side_req = ($urandom_range(0, 11) == 0);
      if (i >= 1000 && i < 1200) ped_req = 1;
      else ped_req = ($urandom_range(0, 14) == 0);
      if (i == 2500) begin
        #2 rst = 1;
        @(negedge clk); #2 rst = 0;
      end
      @(posedge clk); #1;
    end
    side_req = 0; ped_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
